// File: rtl/de_stage_hz_if.sv
// FE/AGEX/MEM/WB facing bundle of the RV32I decode stage and its DE pipeline latch.
// Optional forwarding signals exist only when DE_FWD_EN is defined.
interface de_stage_hz_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5
);
  logic                 fe_valid_i;
  logic [31:0]          fe_inst_i;
  logic [DBITS-1:0]     fe_pc_i;
  logic                 de_stall_o;
  logic                 de_flush_i;
  logic                 agex_we_i;
  logic [REGNOBITS-1:0] agex_rd_i;
  logic                 mem_we_i;
  logic [REGNOBITS-1:0] mem_rd_i;
  logic                 wb_we_i;
  logic [REGNOBITS-1:0] wb_rd_i;
  logic [DBITS-1:0]     wb_data_i;
`ifdef DE_FWD_EN
  logic                 agex_fwd_ok_i;
  logic [DBITS-1:0]     agex_fwd_data_i;
  logic [DBITS-1:0]     mem_fwd_data_i;
`endif
  logic                 de_valid_o;
  logic [31:0]          de_inst_o;
  logic [DBITS-1:0]     de_pc_o;
  logic [6:0]           de_op_o;
  logic [2:0]           de_f3_o;
  logic [6:0]           de_f7_o;
  logic [DBITS-1:0]     de_rs1val_o;
  logic [DBITS-1:0]     de_rs2val_o;
  logic [DBITS-1:0]     de_imm_o;
  logic                 de_is_br_o;
  logic                 de_is_jmp_o;
  logic                 de_rd_mem_o;
  logic                 de_wr_mem_o;
  logic                 de_wr_reg_o;
  logic [REGNOBITS-1:0] de_wregno_o;
  logic                 de_illegal_o;

  modport slave (
`ifdef DE_FWD_EN
    input  agex_fwd_ok_i, agex_fwd_data_i, mem_fwd_data_i,
`endif
    input  fe_valid_i, fe_inst_i, fe_pc_i, de_flush_i,
    input  agex_we_i, agex_rd_i, mem_we_i, mem_rd_i,
    input  wb_we_i, wb_rd_i, wb_data_i,
    output de_stall_o,
    output de_valid_o, de_inst_o, de_pc_o, de_op_o, de_f3_o, de_f7_o,
    output de_rs1val_o, de_rs2val_o, de_imm_o,
    output de_is_br_o, de_is_jmp_o, de_rd_mem_o, de_wr_mem_o, de_wr_reg_o,
    output de_wregno_o, de_illegal_o
  );

  modport master (
`ifdef DE_FWD_EN
    output agex_fwd_ok_i, agex_fwd_data_i, mem_fwd_data_i,
`endif
    output fe_valid_i, fe_inst_i, fe_pc_i, de_flush_i,
    output agex_we_i, agex_rd_i, mem_we_i, mem_rd_i,
    output wb_we_i, wb_rd_i, wb_data_i,
    input  de_stall_o,
    input  de_valid_o, de_inst_o, de_pc_o, de_op_o, de_f3_o, de_f7_o,
    input  de_rs1val_o, de_rs2val_o, de_imm_o,
    input  de_is_br_o, de_is_jmp_o, de_rd_mem_o, de_wr_mem_o, de_wr_reg_o,
    input  de_wregno_o, de_illegal_o
  );
endinterface

// File: rtl/de_stage_hz.sv
// RV32I decode stage: decode, register file with WB bypass, RAW hazard stall, DE latch.
// Define DE_FWD_EN to add AGEX/MEM operand forwarding (AGEX stalls only when not ready).
module de_stage_hz #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  de_stage_hz_if.slave bus
);

  localparam int REGWORDS = 1 << REGNOBITS;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [DBITS-1:0]     regs [REGWORDS];

  logic [31:0]          inst;
  logic [6:0]           op;
  logic [REGNOBITS-1:0] rd_idx;
  logic [REGNOBITS-1:0] rs_idx [2];
  logic                 rs_used [2];
  logic [DBITS-1:0]     src_val [2];
  logic                 agex_hit [2];
  logic                 mem_hit [2];

  logic [31:0]          imm32;
  logic [DBITS-1:0]     imm_ext;
  logic                 is_br, is_jmp, rd_mem, wr_mem, wr_reg_raw, wr_reg, illegal;
  logic                 hazard;

  assign inst      = bus.fe_inst_i;
  assign op        = inst[6:0];
  assign rd_idx    = inst[7 +: REGNOBITS];
  assign rs_idx[0] = inst[15 +: REGNOBITS];
  assign rs_idx[1] = inst[20 +: REGNOBITS];

  always_comb begin
    imm32      = '0;
    is_br      = 1'b0;
    is_jmp     = 1'b0;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    wr_reg_raw = 1'b0;
    illegal    = 1'b0;
    rs_used[0] = 1'b0;
    rs_used[1] = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        imm32      = {inst[31:12], 12'b0};
        wr_reg_raw = 1'b1;
      end
      OP_JAL: begin
        imm32      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        is_jmp     = 1'b1;
        wr_reg_raw = 1'b1;
      end
      OP_JALR: begin
        imm32      = {{20{inst[31]}}, inst[31:20]};
        is_jmp     = 1'b1;
        wr_reg_raw = 1'b1;
        rs_used[0] = 1'b1;
      end
      OP_BRANCH: begin
        imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        is_br      = 1'b1;
        rs_used[0] = 1'b1;
        rs_used[1] = 1'b1;
      end
      OP_LOAD: begin
        imm32      = {{20{inst[31]}}, inst[31:20]};
        rd_mem     = 1'b1;
        wr_reg_raw = 1'b1;
        rs_used[0] = 1'b1;
      end
      OP_STORE: begin
        imm32      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        wr_mem     = 1'b1;
        rs_used[0] = 1'b1;
        rs_used[1] = 1'b1;
      end
      OP_OPIMM: begin
        imm32      = {{20{inst[31]}}, inst[31:20]};
        wr_reg_raw = 1'b1;
        rs_used[0] = 1'b1;
      end
      OP_OP: begin
        wr_reg_raw = 1'b1;
        rs_used[0] = 1'b1;
        rs_used[1] = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wr_reg  = wr_reg_raw && (rd_idx != '0);
  assign imm_ext = DBITS'(signed'(imm32));

  // Later overrides win, giving AGEX > MEM > WB > regfile; x0 always reads zero.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      agex_hit[k] = rs_used[k] && (rs_idx[k] != '0) && bus.agex_we_i && (rs_idx[k] == bus.agex_rd_i);
      mem_hit[k]  = rs_used[k] && (rs_idx[k] != '0) && bus.mem_we_i && (rs_idx[k] == bus.mem_rd_i);
      src_val[k]  = regs[rs_idx[k]];
      if (bus.wb_we_i && (bus.wb_rd_i == rs_idx[k]))
        src_val[k] = bus.wb_data_i;
`ifdef DE_FWD_EN
      if (mem_hit[k])
        src_val[k] = bus.mem_fwd_data_i;
      if (agex_hit[k] && bus.agex_fwd_ok_i)
        src_val[k] = bus.agex_fwd_data_i;
`endif
      if (rs_idx[k] == '0)
        src_val[k] = '0;
    end
  end

`ifdef DE_FWD_EN
  assign hazard = bus.fe_valid_i && ((agex_hit[0] || agex_hit[1]) && !bus.agex_fwd_ok_i);
`else
  assign hazard = bus.fe_valid_i && (agex_hit[0] || agex_hit[1] || mem_hit[0] || mem_hit[1]);
`endif

  // A flush redirects FE anyway, so holding it would only delay the redirect.
  assign bus.de_stall_o = hazard && !bus.de_flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGWORDS; i++)
        regs[i] <= '0;
    end else if (bus.wb_we_i && (bus.wb_rd_i != '0)) begin
      regs[bus.wb_rd_i] <= bus.wb_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.de_flush_i || hazard || !bus.fe_valid_i) begin
      bus.de_valid_o   <= 1'b0;
      bus.de_inst_o    <= '0;
      bus.de_pc_o      <= '0;
      bus.de_op_o      <= '0;
      bus.de_f3_o      <= '0;
      bus.de_f7_o      <= '0;
      bus.de_rs1val_o  <= '0;
      bus.de_rs2val_o  <= '0;
      bus.de_imm_o     <= '0;
      bus.de_is_br_o   <= 1'b0;
      bus.de_is_jmp_o  <= 1'b0;
      bus.de_rd_mem_o  <= 1'b0;
      bus.de_wr_mem_o  <= 1'b0;
      bus.de_wr_reg_o  <= 1'b0;
      bus.de_wregno_o  <= '0;
      bus.de_illegal_o <= 1'b0;
    end else begin
      bus.de_valid_o   <= 1'b1;
      bus.de_inst_o    <= inst;
      bus.de_pc_o      <= bus.fe_pc_i;
      bus.de_op_o      <= op;
      bus.de_f3_o      <= inst[14:12];
      bus.de_f7_o      <= inst[31:25];
      bus.de_rs1val_o  <= src_val[0];
      bus.de_rs2val_o  <= src_val[1];
      bus.de_imm_o     <= imm_ext;
      bus.de_is_br_o   <= is_br;
      bus.de_is_jmp_o  <= is_jmp;
      bus.de_rd_mem_o  <= rd_mem;
      bus.de_wr_mem_o  <= wr_mem;
      bus.de_wr_reg_o  <= wr_reg;
      bus.de_wregno_o  <= wr_reg ? rd_idx : '0;
      bus.de_illegal_o <= illegal;
    end
  end

endmodule
